snail_char_tx: RTL and testbench
================================

Name: snail_char_tx

Overview:
- Memory-mapped character output peripheral for the SNAIL system; sits downstream of the CPU's RAM write port.
- Snoops CPU data-memory writes that fall in a fixed address window and queues each written byte in a small FIFO.
- Serialises queued bytes as 8N1 asynchronous serial on `tx`, so programs can emit text without a bench-side RAM dump.
- The RAM still performs the write; this block only observes the bus.

Parameters:
- WIN_BASE, 8'h00, first RAM address of the snooped window.
- WIN_LEN, 32, number of consecutive addresses in the window; window end = WIN_BASE+WIN_LEN-1, no wrap past 8'hFF.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CLKS_PER_BIT, 16, clk cycles per serial bit; minimum 2.

Ports:
- clk, input, 1, system clock, all state on rising edge.
- rst_, input, 1, asynchronous active-low reset.
- ram_addr, input, 8, CPU data-memory address (shared with RAM).
- ram_wdat, input, 8, CPU write data (shared with RAM).
- ram_wr_, input, 1, CPU write strobe, active low.
- tx, output, 1, serial output, idle high.
- busy, output, 1, high while FIFO non-empty or transmitter not IDLE.
- overflow, output, 1, sticky: a byte was dropped because the FIFO was full.
- fifo_count, output, $clog2(DEPTH)+1, current FIFO occupancy.

Behaviour:
- Reset (rst_=0, asynchronous)
  - tx=1, busy=0, overflow=0, fifo_count=0, FSM=IDLE, bit/baud counters=0, FIFO pointers=0.
  - Reset mid-frame aborts the frame immediately: tx goes high without waiting for clk, and all queued bytes are discarded.
- Capture
  - A write is accepted on a rising edge where ram_wr_=0 and WIN_BASE <= ram_addr <= WIN_BASE+WIN_LEN-1.
  - Accepted write pushes ram_wdat; one push per write-active edge. A held strobe pushes every cycle, matching the RAM, which also writes every cycle.
  - Addresses outside the window, or ram_wr_=1, are ignored.
- Full and overflow
  - Push is accepted if count<DEPTH, or if count=DEPTH and a pop occurs on the same edge.
  - Otherwise the byte is dropped and overflow is set to 1; it stays set until reset.
- Simultaneous push and pop: count is unchanged, and the popped byte is the oldest entry, never the one being pushed.
- Transmit FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty at the edge, pop the head into the shift register, tx<=0, baud counter<=0, go to START. Otherwise tx=1.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then tx<=shift[0], bit index<=0, go to DATA.
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit 7 completes, tx<=1 and go to STOP.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - IDLE may pop on the very next edge, so back-to-back frames have no extra idle time. One frame = 10*CLKS_PER_BIT cycles.
- Latency
  - Write accepted at edge N into an empty FIFO with the FSM IDLE → fifo_count=1 after edge N.
  - Pop and tx falls after edge N+1; fifo_count returns to 0 after edge N+1.
- Registering and width rules
  - tx is a registered output: no combinational path from bus inputs to tx.
  - busy is combinational from the registered state only: (FSM!=IDLE) || (fifo_count!=0).
  - Counters use exact widths: baud $clog2(CLKS_PER_BIT), bit index 3 bits, pointers $clog2(DEPTH) wrapping naturally.

Decomposition:
- Shared package snail_pkg holds:
  - the tx FSM state enum (IDLE, START, DATA, STOP);
  - the default window constants (WIN_BASE, WIN_LEN);
  - the frame bit count (10).
- One sub-module is natural: snail_byte_fifo.
  - Synchronous push/pop, DEPTH entries, outputs head/count/full/empty, same clk/rst_.
  - Full-with-pop push acceptance is decided in the parent.

Test Plan (CLKS_PER_BIT=4, DEPTH=4, WIN_BASE=0, WIN_LEN=32):
- Single byte: write 8'h41 to addr 5 at edge N → fifo_count=1 after N; tx=0 over edges N+1..N+4; bits 1,0,0,0,0,0,1,0 each 4 cycles; stop bit high; busy low after 40 cycles from N+1.
- Window filtering: writes to addr 31 (8'h5A) and 32 (8'h33), plus ram_wr_=1 at addr 3 → exactly one frame carrying 8'h5A; fifo_count never exceeds 1.
- Overflow: six consecutive write cycles 8'h30..8'h35 while idle → frames 30,31,32,33,34 in order; 8'h35 dropped; overflow=1 and stays 1 after the FIFO drains.
- Full with simultaneous pop: fill to 4 while the first frame finishes, then write 8'h7E on the same edge IDLE pops → accepted, overflow stays 0, 8'h7E is the last frame.
- Reset mid-frame: assert rst_=0 during DATA bit 3 between edges → tx=1, busy=0, fifo_count=0 immediately. After release, a new write of 8'h55 transmits a clean full frame.
- Back-to-back: two writes 8'h00, 8'hFF on consecutive cycles → second start bit begins exactly 40 cycles after the first; no idle gap.

Source files
------------

// File: rtl/snail_char_tx_pkg.sv
// Shared types and default constants for the SNAIL character output peripheral.
package snail_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  localparam logic [7:0] WIN_BASE_DEF = 8'h00;
  localparam int         WIN_LEN_DEF  = 32;

  // start + 8 data + stop
  localparam int         FRAME_BITS   = 10;

endpackage

// File: rtl/snail_char_tx_if.sv
// Bus snoop inputs and serial/status outputs of the character transmitter.
interface snail_char_tx_if #(
  parameter int DEPTH = 8
);
  logic [7:0]              ram_addr;
  logic [7:0]              ram_wdat;
  logic                    ram_wr_;
  logic                    tx;
  logic                    busy;
  logic                    overflow;
  logic [$clog2(DEPTH):0]  fifo_count;

  modport master (
    output ram_addr, ram_wdat, ram_wr_,
    input  tx, busy, overflow, fifo_count
  );

  modport slave (
    input  ram_addr, ram_wdat, ram_wr_,
    output tx, busy, overflow, fifo_count
  );
endinterface

// File: rtl/snail_byte_fifo.sv
// Byte FIFO with combinational head; push acceptance is gated by the parent.
module snail_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   i_push,
  input  logic [7:0]             i_data,
  input  logic                   i_pop,
  output logic [7:0]             o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally; occupancy tracks push/pop, unchanged when both.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (i_push && !i_pop)      r_count <= r_count + CW'(1);
      else if (!i_push && i_pop) r_count <= r_count - CW'(1);
    end
  end

  // Head is read before the edge, so a same-edge push never replaces it.
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
endmodule

// File: rtl/snail_char_tx.sv
// Snoops CPU RAM writes into a fixed window and sends each byte as 8N1 serial.
//
// state    | meaning
// TX_IDLE  | line high; pops FIFO head and drives start bit when non-empty
// TX_START | start bit (low) for CLKS_PER_BIT cycles
// TX_DATA  | 8 data bits, LSB first, CLKS_PER_BIT cycles each
// TX_STOP  | stop bit (high); the following IDLE cycle completes it
module snail_char_tx
  import snail_pkg::*;
#(
  parameter logic [7:0] WIN_BASE     = WIN_BASE_DEF,
  parameter int         WIN_LEN      = WIN_LEN_DEF,
  parameter int         DEPTH        = 8,
  parameter int         CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            rst_,
  snail_char_tx_if.slave  bus
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  // STOP ends one cycle early because the IDLE cycle that may pop is
  // still driving high; this keeps a frame at exactly 10 bit times.
  localparam logic [BW-1:0] STOP_LAST = BW'(CLKS_PER_BIT - 2);

  tx_state_t r_state, w_state_nxt;
  logic          r_tx, w_tx_nxt;
  logic [BW-1:0] r_baud, w_baud_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_overflow;

  logic [8:0]             w_off;
  logic                   w_in_win;
  logic                   w_wr_req;
  logic                   w_push;
  logic                   w_pop;
  logic [7:0]             w_head;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_baud_tc;
  logic                   w_stop_tc;

  // Addresses below the base wrap to a large offset and fall outside.
  assign w_off    = {1'b0, bus.ram_addr} - {1'b0, WIN_BASE};
  assign w_in_win = (w_off < 9'(WIN_LEN));
  assign w_wr_req = !bus.ram_wr_ && w_in_win;
  assign w_pop    = (r_state == TX_IDLE) && !w_empty;
  assign w_push   = w_wr_req && (!w_full || w_pop);

  assign w_baud_tc = (r_baud == BAUD_LAST);
  assign w_stop_tc = (r_baud == STOP_LAST);

  snail_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_    (rst_),
    .i_push  (w_push),
    .i_data  (bus.ram_wdat),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Sticky flag for any in-window write that found no room.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)                    r_overflow <= 1'b0;
    else if (w_wr_req && !w_push) r_overflow <= 1'b1;
  end

  // State and datapath registers; reset forces the line high immediately.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= TX_IDLE;
      r_tx    <= 1'b1;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      TX_IDLE:  if (!w_empty)                    w_state_nxt = TX_START;
      TX_START: if (w_baud_tc)                   w_state_nxt = TX_DATA;
      TX_DATA:  if (w_baud_tc && r_bit == 3'd7)  w_state_nxt = TX_STOP;
      TX_STOP:  if (w_stop_tc)                   w_state_nxt = TX_IDLE;
      default:                                   w_state_nxt = TX_IDLE;
    endcase
  end

  // Next values for line, baud counter, bit index and shift register.
  always_comb begin
    w_tx_nxt    = r_tx;
    w_baud_nxt  = r_baud + BW'(1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    case (r_state)
      TX_IDLE: begin
        w_tx_nxt   = 1'b1;
        w_baud_nxt = '0;
        if (!w_empty) begin
          w_shift_nxt = w_head;
          w_tx_nxt    = 1'b0;
        end
      end
      TX_START: begin
        if (w_baud_tc) begin
          w_tx_nxt   = r_shift[0];
          w_bit_nxt  = '0;
          w_baud_nxt = '0;
        end
      end
      TX_DATA: begin
        if (w_baud_tc) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_tx_nxt = 1'b1;
          end else begin
            w_tx_nxt    = r_shift[1];
            w_shift_nxt = r_shift >> 1;
            w_bit_nxt   = r_bit + 3'd1;
          end
        end
      end
      TX_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_stop_tc) w_baud_nxt = '0;
      end
      default: w_tx_nxt = 1'b1;
    endcase
  end

  assign bus.tx         = r_tx;
  assign bus.busy       = (r_state != TX_IDLE) || (w_count != '0);
  assign bus.overflow   = r_overflow;
  assign bus.fifo_count = w_count;
endmodule

// File: tb/tb_snail_char_tx.sv
// Self-checking bench: expected bytes are queued when written, a line monitor
// decodes 8N1 frames from tx, and each test compares the two queues.
module tb_snail_char_tx;
  import snail_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = FRAME_BITS * CPB;

  typedef struct {
    logic [7:0] data;
    int         start;
    bit         ok;
  } rx_t;

  logic clk = 1'b0;
  logic rst_;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [2:0] max_cnt = '0;

  logic [7:0] exp_q[$];
  rx_t        rx_q[$];

  snail_char_tx_if #(.DEPTH(DEPTH)) bus ();

  snail_char_tx #(
    .WIN_BASE(8'h00), .WIN_LEN(32), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)
  ) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (bus.fifo_count > max_cnt) max_cnt = bus.fifo_count;

  // Line monitor: samples mid-bit on falling edges, drops frames cut by reset.
  initial begin : monitor
    logic prev;
    logic [7:0] d;
    bit abort, ok;
    rx_t f;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_ === 1'b1 && prev === 1'b1 && bus.tx === 1'b0) begin
        f.start = cyc; abort = 0; ok = 1; d = '0;
        for (int n = 1; n <= 37; n++) begin
          @(negedge clk);
          if (rst_ !== 1'b1) begin abort = 1; break; end
          if (n == 2 && bus.tx !== 1'b0) ok = 0;
          if (n >= 5 && n <= 33 && (n % 4) == 1) d[(n - 5) / 4] = bus.tx;
          if (n == 37 && bus.tx !== 1'b1) ok = 0;
        end
        if (!abort) begin f.data = d; f.ok = ok; rx_q.push_back(f); end
      end
      prev = (rst_ === 1'b1) ? bus.tx : 1'b1;
    end
  end

  task automatic bus_cycle(input logic [7:0] a, input logic [7:0] d, input logic wr_n);
    @(negedge clk);
    bus.ram_addr = a; bus.ram_wdat = d; bus.ram_wr_ = wr_n;
  endtask

  task automatic wait_drain(input int limit, output bit timed_out);
    int n = 0;
    while ((bus.busy !== 1'b0 || rx_q.size() < exp_q.size()) && n < limit) begin
      @(negedge clk); n++;
    end
    timed_out = (n >= limit);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_ = 1'b0;
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", bus.tx); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count); end
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
  endtask

  task automatic test_single();
    bit to; logic [7:0] e; rx_t f;
    bus_cycle(8'd5, 8'h41, 1'b0); exp_q.push_back(8'h41);
    bus_cycle(8'd0, 8'h00, 1'b1);
    checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL single_count_n: got %0d want 1", bus.fifo_count); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++; if (bus.tx !== 1'b0) begin errors++; $display("FAIL single_start_bit: cycle N+%0d got %b want 0", i, bus.tx); end
    end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL single_count_pop: got %0d want 0", bus.fifo_count); end
    @(negedge clk);
    checks++; if (bus.tx !== 1'b1) begin errors++; $display("FAIL single_bit0: got %b want 1", bus.tx); end
    repeat (34) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_n39: got %b want 1", bus.busy); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_n40: got %b want 0", bus.busy); end
    wait_drain(200, to);
    checks++; if (to) begin errors++; $display("FAIL single_drain: timed out busy=%b", bus.busy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rx_q.size() == 0) begin errors++; $display("FAIL single_frame: missing, want %h", e); end
      else begin
        f = rx_q.pop_front();
        if (f.data !== e || !f.ok) begin errors++; $display("FAIL single_frame: got %h ok=%0d want %h", f.data, f.ok, e); end
      end
    end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL single_extra: %0d extra frames want 0", rx_q.size()); rx_q.delete(); end
  endtask

  task automatic test_window();
    bit to; logic [7:0] e; rx_t f;
    @(negedge clk); max_cnt = '0;
    bus_cycle(8'd31, 8'h5A, 1'b0); exp_q.push_back(8'h5A);
    bus_cycle(8'd32, 8'h33, 1'b0);
    bus_cycle(8'd3,  8'hAA, 1'b1);
    bus_cycle(8'd0,  8'h00, 1'b1);
    wait_drain(300, to);
    checks++; if (to) begin errors++; $display("FAIL window_drain: timed out busy=%b", bus.busy); end
    checks++; if (max_cnt !== 3'd1) begin errors++; $display("FAIL window_max_count: got %0d want 1", max_cnt); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rx_q.size() == 0) begin errors++; $display("FAIL window_frame: missing, want %h", e); end
      else begin
        f = rx_q.pop_front();
        if (f.data !== e || !f.ok) begin errors++; $display("FAIL window_frame: got %h ok=%0d want %h", f.data, f.ok, e); end
      end
    end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL window_extra: %0d extra frames want 0", rx_q.size()); rx_q.delete(); end
  endtask

  task automatic test_overflow();
    bit to; logic [7:0] e; rx_t f;
    for (int i = 0; i < 6; i++) begin
      bus_cycle(8'(i), 8'(8'h30 + i), 1'b0);
      if (i < 5) exp_q.push_back(8'(8'h30 + i));
    end
    bus_cycle(8'd0, 8'h00, 1'b1);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", bus.overflow); end
    checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d want 4", bus.fifo_count); end
    wait_drain(1000, to);
    checks++; if (to) begin errors++; $display("FAIL ovf_drain: timed out busy=%b", bus.busy); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rx_q.size() == 0) begin errors++; $display("FAIL ovf_frame: missing, want %h", e); end
      else begin
        f = rx_q.pop_front();
        if (f.data !== e || !f.ok) begin errors++; $display("FAIL ovf_frame: got %h ok=%0d want %h", f.data, f.ok, e); end
      end
    end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL ovf_extra: %0d extra frames want 0", rx_q.size()); rx_q.delete(); end
    pulse_reset();
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", bus.overflow); end
  endtask

  task automatic test_full_pop();
    bit to; logic [7:0] e; rx_t f;
    for (int i = 0; i < 5; i++) begin
      bus_cycle(8'(i), 8'(8'h10 + i), 1'b0); exp_q.push_back(8'(8'h10 + i));
    end
    repeat (36) bus_cycle(8'd0, 8'h00, 1'b1);
    @(negedge clk);
    checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL fullpop_prefill: got %0d want 4", bus.fifo_count); end
    bus.ram_addr = 8'd20; bus.ram_wdat = 8'h7E; bus.ram_wr_ = 1'b0; exp_q.push_back(8'h7E);
    @(negedge clk); bus.ram_wr_ = 1'b1;
    checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL fullpop_count: got %0d want 4", bus.fifo_count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf: got %b want 0", bus.overflow); end
    wait_drain(1000, to);
    checks++; if (to) begin errors++; $display("FAIL fullpop_drain: timed out busy=%b", bus.busy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rx_q.size() == 0) begin errors++; $display("FAIL fullpop_frame: missing, want %h", e); end
      else begin
        f = rx_q.pop_front();
        if (f.data !== e || !f.ok) begin errors++; $display("FAIL fullpop_frame: got %h ok=%0d want %h", f.data, f.ok, e); end
      end
    end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL fullpop_extra: %0d extra frames want 0", rx_q.size()); rx_q.delete(); end
  endtask

  task automatic test_reset_mid();
    bit to; logic [7:0] e; rx_t f;
    bus_cycle(8'd7, 8'hC3, 1'b0);
    bus_cycle(8'd8, 8'h99, 1'b0);
    bus_cycle(8'd0, 8'h00, 1'b1);
    repeat (17) @(negedge clk);
    checks++; if (bus.tx !== 1'b0) begin errors++; $display("FAIL rstmid_bit3: got %b want 0", bus.tx); end
    checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL rstmid_queued: got %0d want 1", bus.fifo_count); end
    #2 rst_ = 1'b0;
    #1;
    checks++; if (bus.tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b want 1", bus.tx); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", bus.fifo_count); end
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    bus_cycle(8'd9, 8'h55, 1'b0); exp_q.push_back(8'h55);
    bus_cycle(8'd0, 8'h00, 1'b1);
    wait_drain(300, to);
    checks++; if (to) begin errors++; $display("FAIL rstmid_drain: timed out busy=%b", bus.busy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rx_q.size() == 0) begin errors++; $display("FAIL rstmid_frame: missing, want %h", e); end
      else begin
        f = rx_q.pop_front();
        if (f.data !== e || !f.ok) begin errors++; $display("FAIL rstmid_frame: got %h ok=%0d want %h", f.data, f.ok, e); end
      end
    end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL rstmid_extra: %0d extra frames want 0", rx_q.size()); rx_q.delete(); end
  endtask

  task automatic test_back_to_back();
    bit to; logic [7:0] e; rx_t f; int starts[$];
    bus_cycle(8'd0, 8'h00, 1'b0); exp_q.push_back(8'h00);
    bus_cycle(8'd1, 8'hFF, 1'b0); exp_q.push_back(8'hFF);
    bus_cycle(8'd0, 8'h00, 1'b1);
    wait_drain(400, to);
    checks++; if (to) begin errors++; $display("FAIL b2b_drain: timed out busy=%b", bus.busy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rx_q.size() == 0) begin errors++; $display("FAIL b2b_frame: missing, want %h", e); end
      else begin
        f = rx_q.pop_front(); starts.push_back(f.start);
        if (f.data !== e || !f.ok) begin errors++; $display("FAIL b2b_frame: got %h ok=%0d want %h", f.data, f.ok, e); end
      end
    end
    checks++;
    if (starts.size() != 2) begin errors++; $display("FAIL b2b_gap: got %0d frames want 2", starts.size()); end
    else if (starts[1] - starts[0] != FRAME) begin
      errors++; $display("FAIL b2b_gap: got %0d cycles want %0d", starts[1] - starts[0], FRAME);
    end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL b2b_extra: %0d extra frames want 0", rx_q.size()); rx_q.delete(); end
  endtask

  initial begin
    bus.ram_addr = 8'h00; bus.ram_wdat = 8'h00; bus.ram_wr_ = 1'b1;
    rst_ = 1'b1;
    #1 rst_ = 1'b0;
    test_reset();
    test_single();
    test_window();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
